// File: rtl/alu_ex_mem_reg.sv
// EX/MEM pipeline register behind the ALU add/sub datapath.
// Registers the ALU result, flags, control and store data for the MEM stage.
// A signed overflow on a trapping instruction becomes a precise exception
// request to CP0, held until CP0 acknowledges it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal pipelining; flush > stall > capture
//   TRAP  | overflow exception pending; MEM stage sees bubbles until exc_ack
module alu_ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic              in_ovf_trap,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [4:0]        in_wb_dst,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              exc_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu_out,
  output logic              out_zero,
  output logic              out_negative,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [4:0]        out_wb_dst,
  output logic [DATA_W-1:0] out_store_data,
  output logic              exc_req,
  output logic [DATA_W-1:0] exc_epc,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t state;
  logic   trap_hit;
  logic   load_bubble;
  logic   load_capture;
  logic   take_trap;

  assign trap_hit = in_valid & in_ovf_trap & in_overflow;

  // Decide what the stage register does on the coming edge
  always_comb begin
    load_bubble  = 1'b0;
    load_capture = 1'b0;
    take_trap    = 1'b0;
    if (state == TRAP) begin
      load_bubble = 1'b1;
    end else if (flush_i) begin
      load_bubble = 1'b1;
    end else if (!stall_i) begin
      load_capture = 1'b1;
      take_trap    = trap_hit;
    end
  end

  // Pipeline register: bubble, capture (controls squashed on a trap) or hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_alu_out    <= '0;
      out_zero       <= 1'b0;
      out_negative   <= 1'b0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_wb_dst     <= '0;
      out_store_data <= '0;
    end else if (load_bubble) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_alu_out    <= '0;
      out_zero       <= 1'b0;
      out_negative   <= 1'b0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_wb_dst     <= '0;
      out_store_data <= '0;
    end else if (load_capture) begin
      out_valid      <= in_valid;
      out_pc         <= in_pc;
      out_alu_out    <= in_alu_out;
      out_zero       <= in_zero;
      out_negative   <= in_negative;
      out_reg_write  <= in_reg_write & ~take_trap;
      out_mem_read   <= in_mem_read & ~take_trap;
      out_mem_write  <= in_mem_write & ~take_trap;
      out_wb_dst     <= in_wb_dst;
      out_store_data <= in_store_data;
    end
  end

  // Exception FSM: raise on a captured trap, drop on CP0 acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      exc_req   <= 1'b0;
      exc_epc   <= '0;
      ovf_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (take_trap) begin
            state   <= TRAP;
            exc_req <= 1'b1;
            exc_epc <= in_pc;
            if (ovf_count != {CNT_W{1'b1}}) begin
              ovf_count <= ovf_count + CNT_W'(1);
            end
          end
        end
        TRAP: begin
          if (exc_ack) begin
            state   <= RUN;
            exc_req <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ex_mem_reg.sv
// Bench for alu_ex_mem_reg: directed vector table, hand-written multi-cycle
// sequences and randomized stimulus against a behavioural model.
// Two instances share all inputs; the second has a 2-bit trap counter.
module tb_alu_ex_mem_reg;

  logic        clk;
  logic        reset;
  logic        stall_i, flush_i, in_valid;
  logic [31:0] in_pc, in_alu_out, in_store_data;
  logic        in_zero, in_negative, in_overflow, in_ovf_trap;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic [4:0]  in_wb_dst;
  logic        exc_ack;

  logic        out_valid, out_zero, out_negative, out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_pc, out_alu_out, out_store_data, exc_epc;
  logic [4:0]  out_wb_dst;
  logic        exc_req;
  logic [7:0]  ovf_count;

  logic        b_valid, b_zero, b_negative, b_reg_write, b_mem_read, b_mem_write;
  logic [31:0] b_pc, b_alu_out, b_store_data, b_epc;
  logic [4:0]  b_wb_dst;
  logic        b_exc_req;
  logic [1:0]  b_count;

  alu_ex_mem_reg #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_zero(in_zero), .in_negative(in_negative), .in_overflow(in_overflow),
    .in_ovf_trap(in_ovf_trap), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_wb_dst(in_wb_dst), .in_store_data(in_store_data), .exc_ack(exc_ack),
    .out_valid(out_valid), .out_pc(out_pc), .out_alu_out(out_alu_out),
    .out_zero(out_zero), .out_negative(out_negative),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_wb_dst(out_wb_dst),
    .out_store_data(out_store_data), .exc_req(exc_req), .exc_epc(exc_epc),
    .ovf_count(ovf_count)
  );

  alu_ex_mem_reg #(.DATA_W(32), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_zero(in_zero), .in_negative(in_negative), .in_overflow(in_overflow),
    .in_ovf_trap(in_ovf_trap), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_wb_dst(in_wb_dst), .in_store_data(in_store_data), .exc_ack(exc_ack),
    .out_valid(b_valid), .out_pc(b_pc), .out_alu_out(b_alu_out),
    .out_zero(b_zero), .out_negative(b_negative),
    .out_reg_write(b_reg_write), .out_mem_read(b_mem_read),
    .out_mem_write(b_mem_write), .out_wb_dst(b_wb_dst),
    .out_store_data(b_store_data), .exc_req(b_exc_req), .exc_epc(b_epc),
    .ovf_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid, m_zero, m_neg, m_rw, m_mr, m_mw, m_exc, m_pending;
  logic [31:0] m_pc, m_alu, m_sd, m_epc;
  logic [4:0]  m_dst;
  int          m_traps;

  task automatic m_bubble();
    m_valid = 0; m_pc = 0; m_alu = 0; m_zero = 0; m_neg = 0;
    m_rw = 0; m_mr = 0; m_mw = 0; m_dst = 0; m_sd = 0;
  endtask

  task automatic m_reset();
    m_bubble();
    m_exc = 0; m_epc = 0; m_pending = 0; m_traps = 0;
  endtask

  // One clock edge of the EX/MEM stage, evaluated from the inputs at that edge
  task automatic m_edge();
    if (m_pending) begin
      m_bubble();
      if (exc_ack) begin m_exc = 0; m_pending = 0; end
    end else if (flush_i) begin
      m_bubble();
    end else if (!stall_i) begin
      m_valid = in_valid; m_pc = in_pc; m_alu = in_alu_out;
      m_zero = in_zero; m_neg = in_negative; m_dst = in_wb_dst; m_sd = in_store_data;
      if (in_valid && in_ovf_trap && in_overflow) begin
        m_rw = 0; m_mr = 0; m_mw = 0;
        m_exc = 1; m_epc = in_pc; m_pending = 1; m_traps++;
      end else begin
        m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
      end
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int max);
    return (n > max) ? 32'(max) : 32'(n);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_valid});
    chk({tag, ".pc"}, out_pc, m_pc);
    chk({tag, ".alu"}, out_alu_out, m_alu);
    chk({tag, ".zero"}, {31'b0, out_zero}, {31'b0, m_zero});
    chk({tag, ".neg"}, {31'b0, out_negative}, {31'b0, m_neg});
    chk({tag, ".rw"}, {31'b0, out_reg_write}, {31'b0, m_rw});
    chk({tag, ".mr"}, {31'b0, out_mem_read}, {31'b0, m_mr});
    chk({tag, ".mw"}, {31'b0, out_mem_write}, {31'b0, m_mw});
    chk({tag, ".dst"}, {27'b0, out_wb_dst}, {27'b0, m_dst});
    chk({tag, ".sd"}, out_store_data, m_sd);
    chk({tag, ".exc"}, {31'b0, exc_req}, {31'b0, m_exc});
    chk({tag, ".epc"}, exc_epc, m_epc);
    chk({tag, ".cnt"}, {24'b0, ovf_count}, sat(m_traps, 255));
    chk({tag, ".exc_small"}, {31'b0, b_exc_req}, {31'b0, m_exc});
    chk({tag, ".cnt_small"}, {30'b0, b_count}, sat(m_traps, 3));
  endtask

  // Advance one clock edge, update the model, sample just after the edge
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive_idle();
    stall_i = 0; flush_i = 0; in_valid = 0; in_pc = 0; in_alu_out = 0;
    in_zero = 0; in_negative = 0; in_overflow = 0; in_ovf_trap = 0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_wb_dst = 0;
    in_store_data = 0; exc_ack = 0;
  endtask

  task automatic drive_random(input bit rare_ctl);
    stall_i       = rare_ctl ? ($urandom_range(0, 7) == 0) : 1'($urandom);
    flush_i       = rare_ctl ? ($urandom_range(0, 9) == 0) : 1'($urandom);
    in_valid      = ($urandom_range(0, 3) != 0);
    in_pc         = $urandom;
    in_alu_out    = $urandom;
    in_zero       = 1'($urandom);
    in_negative   = 1'($urandom);
    in_overflow   = ($urandom_range(0, 3) == 0);
    in_ovf_trap   = 1'($urandom);
    in_reg_write  = 1'($urandom);
    in_mem_read   = 1'($urandom);
    in_mem_write  = 1'($urandom);
    in_wb_dst     = 5'($urandom);
    in_store_data = $urandom;
    exc_ack       = ($urandom_range(0, 2) == 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        flush, stall, valid, ovf, trap, rw, ack;
    logic [31:0] pc, alu;
    logic        e_valid, e_rw, e_exc;
    logic [31:0] e_alu, e_epc;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic st, input logic va,
                              input logic ov, input logic tr, input logic rw,
                              input logic ak, input logic [31:0] pc, input logic [31:0] alu,
                              input logic ev, input logic erw, input logic eexc,
                              input logic [31:0] ealu, input logic [31:0] eepc, input int ecnt);
    vec_t v;
    v.flush = fl; v.stall = st; v.valid = va; v.ovf = ov; v.trap = tr; v.rw = rw; v.ack = ak;
    v.pc = pc; v.alu = alu;
    v.e_valid = ev; v.e_rw = erw; v.e_exc = eexc; v.e_alu = ealu; v.e_epc = eepc; v.e_cnt = ecnt;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    string tag;
    //            fl st va ov tr rw ak  pc            alu           ev rw exc  e_alu         e_epc     cnt
    tbl[0]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h0040_0000, 32'h0000_0005, 1, 1, 0, 32'h0000_0005, 32'h0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 1, 1, 0, 32'h0040_0010, 32'h8000_0000, 1, 0, 1, 32'h8000_0000, 32'h0040_0010, 1);
    tbl[2]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h0040_0014, 32'h0000_0007, 0, 0, 1, 32'h0, 32'h0040_0010, 1);
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 0, 32'h0040_0018, 32'h0000_0008, 0, 0, 1, 32'h0, 32'h0040_0010, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 1, 1, 32'h0040_001c, 32'h0000_0009, 0, 0, 0, 32'h0, 32'h0040_0010, 1);
    tbl[5]  = mk(0, 0, 1, 1, 0, 1, 0, 32'h0040_0020, 32'h0000_0001, 1, 1, 0, 32'h0000_0001, 32'h0040_0010, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h0040_0024, 32'h0000_0011, 1, 1, 0, 32'h0000_0011, 32'h0040_0010, 1);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0040_0028, 32'h0000_0022, 1, 1, 0, 32'h0000_0011, 32'h0040_0010, 1);
    tbl[8]  = mk(0, 1, 0, 1, 1, 0, 0, 32'h0040_002c, 32'h0000_0033, 1, 1, 0, 32'h0000_0011, 32'h0040_0010, 1);
    tbl[9]  = mk(0, 1, 1, 1, 1, 1, 0, 32'h0040_0030, 32'h0000_0044, 1, 1, 0, 32'h0000_0011, 32'h0040_0010, 1);
    tbl[10] = mk(1, 0, 1, 0, 0, 1, 0, 32'h0040_0034, 32'h0000_0055, 0, 0, 0, 32'h0, 32'h0040_0010, 1);
    tbl[11] = mk(1, 0, 1, 1, 1, 1, 0, 32'h0040_0038, 32'h8000_0001, 0, 0, 0, 32'h0, 32'h0040_0010, 1);
    tbl[12] = mk(0, 0, 1, 0, 0, 1, 1, 32'h0040_003c, 32'h0000_0066, 1, 1, 0, 32'h0000_0066, 32'h0040_0010, 1);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 32'h0040_0040, 32'h0000_0077, 0, 0, 0, 32'h0000_0077, 32'h0040_0010, 1);

    // Reset held low with random inputs: everything stays zero
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random(1'b0);
      @(posedge clk);
      #1;
      check_model($sformatf("reset%0d", i));
    end
    drive_idle();
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      drive_idle();
      flush_i = tbl[i].flush; stall_i = tbl[i].stall; in_valid = tbl[i].valid;
      in_overflow = tbl[i].ovf; in_ovf_trap = tbl[i].trap; in_reg_write = tbl[i].rw;
      exc_ack = tbl[i].ack; in_pc = tbl[i].pc; in_alu_out = tbl[i].alu;
      step();
      tag = $sformatf("vec%0d", i);
      chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      chk({tag, ".rw"}, {31'b0, out_reg_write}, {31'b0, tbl[i].e_rw});
      chk({tag, ".alu"}, out_alu_out, tbl[i].e_alu);
      chk({tag, ".exc"}, {31'b0, exc_req}, {31'b0, tbl[i].e_exc});
      chk({tag, ".epc"}, exc_epc, tbl[i].e_epc);
      chk({tag, ".cnt"}, {24'b0, ovf_count}, 32'(tbl[i].e_cnt));
    end
    check_model("post_table");

    // Five acknowledged traps: 8-bit counter reaches 6, 2-bit counter sticks at 3
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      in_valid = 1; in_overflow = 1; in_ovf_trap = 1; in_reg_write = 1;
      in_pc = 32'h0050_0000 + 32'(k * 4); in_alu_out = 32'h7fff_fff0;
      step();
      check_model($sformatf("sat_trap%0d", k));
      drive_idle();
      exc_ack = 1;
      step();
      check_model($sformatf("sat_ack%0d", k));
    end
    chk("sat_small_final", {30'b0, b_count}, 32'd3);
    chk("sat_big_final", {24'b0, ovf_count}, 32'd6);

    // Reset pulsed while an exception is pending: clears without a clock edge
    drive_idle();
    in_valid = 1; in_overflow = 1; in_ovf_trap = 1; in_pc = 32'h0060_0000;
    step();
    chk("pre_reset_exc", {31'b0, exc_req}, 32'd1);
    drive_idle();
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk("async_reset_exc", {31'b0, exc_req}, 32'd0);
    chk("async_reset_exc_small", {31'b0, b_exc_req}, 32'd0);
    chk("async_reset_epc", exc_epc, 32'd0);
    chk("async_reset_cnt", {24'b0, ovf_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_model("after_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_random(1'b1);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
